// File: rtl/rr_arbiter_hold_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Shared state type and one-hot decode helper for the round-robin arbiter.
// Rev    : 1.0
// ============================================================================
package arb_pkg;

    localparam int ARB_MAX_SIZE = 64;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    // OR-reduction decode: no priority chain, valid only for one-hot or zero input.
    function automatic logic [31:0] onehot2bin(input logic [ARB_MAX_SIZE-1:0] oh);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < ARB_MAX_SIZE; i++) begin
            if (oh[i]) begin
                bin = bin | 32'(i);
            end
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_hold_pick_enc.sv
`default_nettype none
// ============================================================================
// Module : rr_pick_enc
// Round-robin pick: lowest request strictly above ptr, else lowest request.
// Rev    : 1.0
// ============================================================================
module rr_pick_enc
    import arb_pkg::*;
#(
    parameter int SIZE = 4,
    localparam int IDW = $clog2(SIZE)
) (
    input  logic [SIZE-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [SIZE-1:0] pick_oh,
    output logic [IDW-1:0]  pick_id,
    output logic            pick_vld
);

    logic [SIZE-1:0]         above_mask;
    logic [SIZE-1:0]         masked;
    logic [SIZE-1:0]         masked_lsb;
    logic [SIZE-1:0]         req_lsb;
    logic [ARB_MAX_SIZE-1:0] pick_ext;

    for (genvar i = 0; i < SIZE; i++) begin : g_mask
        assign above_mask[i] = (i > int'(ptr));
    end

    assign masked     = req & above_mask;
    assign masked_lsb = masked & (~masked + SIZE'(1));
    assign req_lsb    = req & (~req + SIZE'(1));

    assign pick_oh  = (|masked) ? masked_lsb : req_lsb;
    assign pick_vld = |req;
    assign pick_ext = ARB_MAX_SIZE'(pick_oh);
    assign pick_id  = IDW'(onehot2bin(pick_ext));

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter_hold
// Registered round-robin arbiter, grant held until accepted. ARB_LOCK_EN adds lock.
// Rev    : 1.0
// ============================================================================
module rr_arbiter_hold
    import arb_pkg::*;
#(
    parameter int SIZE = 4,
    localparam int IDW = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] req,
    output logic [SIZE-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic            drop_err
`ifdef ARB_LOCK_EN
    ,
    input  logic            lock
`endif
);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  enc_ptr;
    logic [IDW-1:0]  gnt_id_nxt;
    logic [IDW-1:0]  pick_id;
    logic [SIZE-1:0] gnt_nxt;
    logic [SIZE-1:0] pick_oh;
    logic            pick_vld;
    logic            accept;
    logic            lock_hold;
    logic            drop_nxt;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign gnt_valid = |gnt;
    assign accept    = gnt_valid & gnt_ready & req[gnt_id];

    // While busy the next pick rotates past the current grant, not the stored ptr.
    assign enc_ptr = (state == ARB_BUSY) ? gnt_id : ptr;

    rr_pick_enc #(
        .SIZE (SIZE)
    ) u_pick_enc (
        .req      (req),
        .ptr      (enc_ptr),
        .pick_oh  (pick_oh),
        .pick_id  (pick_id),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        drop_nxt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt    = pick_oh;
                    gnt_id_nxt = pick_id;
                    state_nxt  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (accept) begin
                    if (!lock_hold) begin
                        ptr_nxt    = gnt_id;
                        gnt_nxt    = pick_oh;
                        gnt_id_nxt = pick_id;
                        state_nxt  = pick_vld ? ARB_BUSY : ARB_IDLE;
                    end
                end else if (!req[gnt_id]) begin
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    drop_nxt   = 1'b1;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: begin
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                state_nxt  = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= IDW'(SIZE - 1);
            gnt      <= '0;
            gnt_id   <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            drop_err <= drop_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arbiter_hold
// Self-checking bench: scan-order reference model plus directed literal checks.
// Rev    : 1.0
// ============================================================================
module tb_rr_arbiter_hold;

    localparam int SIZE = 4;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic [SIZE-1:0] req       = '0;
    logic            gnt_ready = 1'b0;
    logic            lock      = 1'b0;
    logic [SIZE-1:0] gnt;
    logic [1:0]      gnt_id;
    logic            gnt_valid;
    logic            drop_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_hold #(
        .SIZE (SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .drop_err  (drop_err)
`ifdef ARB_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: grant holder as an index (-1 = none), scanning upward from ptr+1.
    int   m_gnt  = -1;
    int   m_ptr  = SIZE - 1;
    logic m_drop = 1'b0;

    function automatic int pick(input logic [SIZE-1:0] r, input int p);
        int idx;
        for (int k = 1; k <= SIZE; k++) begin
            idx = (p + k) % SIZE;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int exp_oh(input int g);
        return (g < 0) ? 0 : (1 << g);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gnt  <= -1;
            m_ptr  <= SIZE - 1;
            m_drop <= 1'b0;
        end else begin
            m_drop <= 1'b0;
            if (m_gnt < 0) begin
                m_gnt <= pick(req, m_ptr);
            end else if (!req[m_gnt]) begin
                m_gnt  <= -1;
                m_drop <= 1'b1;
            end else if (gnt_ready && !lock) begin
                m_ptr <= m_gnt;
                m_gnt <= pick(req, m_gnt);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_gnt",       int'(gnt),       exp_oh(m_gnt));
        chk("model_gnt_id",    int'(gnt_id),    (m_gnt < 0) ? 0 : m_gnt);
        chk("model_gnt_valid", int'(gnt_valid), (m_gnt >= 0) ? 1 : 0);
        chk("model_drop_err",  int'(drop_err),  int'(m_drop));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req       = '0;
        gnt_ready = 1'b0;
        lock      = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n  = 1'b1;
        @(negedge clk);
    endtask

    localparam int NVEC = 12;
    logic [SIZE-1:0] vec_req   [NVEC] = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1100, 4'b0100,
                                          4'b0000, 4'b0011, 4'b0010, 4'b1001, 4'b1001, 4'b0000};
    logic            vec_ready [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                          1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int              seq2      [5]    = '{0, 1, 2, 3, 0};

    initial begin
        // 1: reset values, idle gnt_ready ignored, one-cycle latency
        do_reset();
        chk("rst_gnt",       int'(gnt),       0);
        chk("rst_gnt_id",    int'(gnt_id),    0);
        chk("rst_gnt_valid", int'(gnt_valid), 0);
        chk("rst_drop_err",  int'(drop_err),  0);
        gnt_ready = 1'b1;
        repeat (2) tick();
        chk("idle_ready_gnt", int'(gnt), 0);
        gnt_ready = 1'b0;
        req = 4'b1010;
        #1 chk("t1_no_same_cycle_gnt", int'(gnt), 0);
        tick();
        chk("t1_gnt",    int'(gnt),    4'b0010);
        chk("t1_gnt_id", int'(gnt_id), 1);

        // 2: full load rotation, no idle bubble
        do_reset();
        req = 4'b1111;
        gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_gnt_id",    int'(gnt_id),    seq2[i]);
            chk("t2_gnt_valid", int'(gnt_valid), 1);
        end

        // 3: held grant is not preempted; accept wraps to 0
        do_reset();
        req = 4'b0100;
        tick();
        chk("t3_gnt_id", int'(gnt_id), 2);
        req = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_gnt", int'(gnt), 4'b0100);
        end
        gnt_ready = 1'b1;
        tick();
        chk("t3_wrap_gnt_id", int'(gnt_id), 0);

        // 4: drop without accept, next pick continues above the unchanged ptr
        do_reset();
        req = 4'b0001;
        tick();
        chk("t4_first_id", int'(gnt_id), 0);
        req = 4'b0011;
        gnt_ready = 1'b1;
        tick();
        chk("t4_second_id", int'(gnt_id), 1);
        req = 4'b0101;
        gnt_ready = 1'b0;
        tick();
        chk("t4_drop_gnt", int'(gnt),      0);
        chk("t4_drop_err", int'(drop_err), 1);
        tick();
        chk("t4_next_id",   int'(gnt_id),   2);
        chk("t4_drop_done", int'(drop_err), 0);

        // 5: asynchronous reset mid-grant
        do_reset();
        req = 4'b1111;
        gnt_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_busy_id", int'(gnt_id), 2);
        gnt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_gnt",       int'(gnt),       0);
        chk("t5_async_gnt_id",    int'(gnt_id),    0);
        chk("t5_async_gnt_valid", int'(gnt_valid), 0);
        chk("t5_async_drop_err",  int'(drop_err),  0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req = 4'b1001;
        tick();
        chk("t5_after_rst_id", int'(gnt_id), 0);

        // mixed vectors, checked by the model only
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            req       = vec_req[i];
            gnt_ready = vec_ready[i];
            tick();
        end

`ifdef ARB_LOCK_EN
        // 6: lock keeps the grant across accepts
        do_reset();
        req = 4'b0011;
        lock = 1'b1;
        tick();
        chk("t6_first_id", int'(gnt_id), 0);
        gnt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_locked_id", int'(gnt_id), 0);
        end
        lock = 1'b0;
        tick();
        chk("t6_unlocked_id", int'(gnt_id), 1);
`endif

        req = '0;
        gnt_ready = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
